// File: rtl/control_unit_pkg.sv
// Shared definitions for the cs147sec05 control unit: opcodes, functs, ALU codes,
// FSM state encodings and CTRL bit indices. Optional trap build: CU_ILLEGAL_TRAP_EN.
package control_unit_pkg;

  typedef logic [2:0] state_t;
  typedef logic [3:0] alu_op_t;
  typedef logic [5:0] opcode_t;

  localparam int unsigned CTRL_W = 32;

  // Opcodes
  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_MULI  = 6'h1d;
  localparam opcode_t OP_ANDI  = 6'h0c;
  localparam opcode_t OP_ORI   = 6'h0d;
  localparam opcode_t OP_LUI   = 6'h0f;
  localparam opcode_t OP_SLTI  = 6'h0a;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_BNE   = 6'h05;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2b;
  localparam opcode_t OP_JMP   = 6'h02;
  localparam opcode_t OP_JAL   = 6'h03;
  localparam opcode_t OP_PUSH  = 6'h1b;
  localparam opcode_t OP_POP   = 6'h1c;

  // R-type functs
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_MUL = 6'h2c;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam alu_op_t ALU_NONE = 4'd0;
  localparam alu_op_t ALU_ADD  = 4'd1;
  localparam alu_op_t ALU_SUB  = 4'd2;
  localparam alu_op_t ALU_MUL  = 4'd3;
  localparam alu_op_t ALU_SHR  = 4'd4;
  localparam alu_op_t ALU_SHL  = 4'd5;
  localparam alu_op_t ALU_AND  = 4'd6;
  localparam alu_op_t ALU_OR   = 4'd7;
  localparam alu_op_t ALU_NOR  = 4'd8;
  localparam alu_op_t ALU_SLT  = 4'd9;

  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXE    = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_HALT   = 3'd5;

  // CTRL bit indices
  localparam int unsigned CB_PC_LOAD   = 0;
  localparam int unsigned CB_PC_SEL_1  = 1;
  localparam int unsigned CB_PC_SEL_2  = 2;
  localparam int unsigned CB_PC_SEL_3  = 3;
  localparam int unsigned CB_IR_LOAD   = 4;
  localparam int unsigned CB_MEM_R     = 5;
  localparam int unsigned CB_MEM_W     = 6;
  localparam int unsigned CB_R1_SEL_1  = 7;
  localparam int unsigned CB_REG_R     = 8;
  localparam int unsigned CB_REG_W     = 9;
  localparam int unsigned CB_WA_SEL_1  = 10;
  localparam int unsigned CB_WA_SEL_2  = 11;
  localparam int unsigned CB_WA_SEL_3  = 12;
  localparam int unsigned CB_WD_SEL_1  = 13;
  localparam int unsigned CB_WD_SEL_2  = 14;
  localparam int unsigned CB_WD_SEL_3  = 15;
  localparam int unsigned CB_SP_LOAD   = 16;
  localparam int unsigned CB_OP1_SEL_1 = 17;
  localparam int unsigned CB_OP2_SEL_1 = 18;
  localparam int unsigned CB_OP2_SEL_2 = 19;
  localparam int unsigned CB_OP2_SEL_3 = 20;
  localparam int unsigned CB_OP2_SEL_4 = 21;
  localparam int unsigned CB_ALU_LSB   = 22;
  localparam int unsigned CB_ALU_MSB   = 25;
  localparam int unsigned CB_MA_SEL_1  = 26;
  localparam int unsigned CB_MA_SEL_2  = 27;
  localparam int unsigned CB_MD_SEL_1  = 28;

  // ALU operation for an arithmetic/logic R-type funct; ALU_NONE for jr or unknown.
  function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
    alu_op_t op;
    case (fn)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_MUL:  op = ALU_MUL;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_NOR:  op = ALU_NOR;
      FN_SLT:  op = ALU_SLT;
      FN_SLL:  op = ALU_SHL;
      FN_SRL:  op = ALU_SHR;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

  function automatic logic is_legal(input opcode_t op, input logic [5:0] fn);
    logic ok;
    case (op)
      OP_RTYPE: ok = (fn == FN_JR) || (funct_to_alu(fn) != ALU_NONE);
      OP_ADDI, OP_MULI, OP_ANDI, OP_ORI, OP_LUI, OP_SLTI, OP_BEQ, OP_BNE,
      OP_LW, OP_SW, OP_JMP, OP_JAL, OP_PUSH, OP_POP: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational CTRL word decode from FSM state, opcode, funct and the captured
// zero flag. Unknown instructions decode as a NOP (PC+1 only).
module ctrl_decode
  import control_unit_pkg::*;
(
  input  state_t      i_state,
  input  opcode_t     i_opcode,
  input  logic [5:0]  i_funct,
  input  logic        i_zero_q,
  output logic [31:0] o_ctrl
);

  alu_op_t     w_alu;
  logic [31:0] w_opnd;
  logic [31:0] w_mem;
  logic [31:0] w_wb;

  // Operand selects and ALU op, held from EXE through WB.
  always_comb begin
    w_alu  = ALU_NONE;
    w_opnd = '0;
    case (i_opcode)
      OP_RTYPE: begin
        w_alu = funct_to_alu(i_funct);
        if (i_funct == FN_SLL || i_funct == FN_SRL) begin
          w_opnd[CB_OP2_SEL_3] = 1'b1;
          w_opnd[CB_OP2_SEL_1] = 1'b1;
        end else if (w_alu != ALU_NONE) begin
          w_opnd[CB_OP2_SEL_4] = 1'b1;
        end
      end
      OP_ADDI, OP_LW, OP_SW: begin
        w_alu = ALU_ADD;
        w_opnd[CB_OP2_SEL_2] = 1'b1;
      end
      OP_SLTI: begin
        w_alu = ALU_SLT;
        w_opnd[CB_OP2_SEL_2] = 1'b1;
      end
      OP_MULI: begin
        w_alu = ALU_MUL;
        w_opnd[CB_OP2_SEL_2] = 1'b1;
      end
      OP_ANDI: w_alu = ALU_AND;
      OP_ORI:  w_alu = ALU_OR;
      OP_BEQ, OP_BNE: begin
        w_alu = ALU_SUB;
        w_opnd[CB_OP2_SEL_4] = 1'b1;
      end
      OP_PUSH, OP_POP: begin
        w_alu = (i_opcode == OP_PUSH) ? ALU_SUB : ALU_ADD;
        w_opnd[CB_OP1_SEL_1] = 1'b1;
        w_opnd[CB_OP2_SEL_3] = 1'b1;
      end
      default: ;
    endcase
    w_opnd[CB_ALU_MSB:CB_ALU_LSB] = w_alu;
  end

  always_comb begin
    w_mem = '0;
    case (i_opcode)
      OP_LW, OP_POP: w_mem[CB_MEM_R] = 1'b1;
      OP_SW:         w_mem[CB_MEM_W] = 1'b1;
      OP_PUSH: begin
        w_mem[CB_MEM_W]    = 1'b1;
        w_mem[CB_MA_SEL_1] = 1'b1;
        w_mem[CB_MD_SEL_1] = 1'b1;
        w_mem[CB_R1_SEL_1] = 1'b1;
      end
      default: ;
    endcase
  end

  // PC defaults to PC+1; each opcode only overrides what differs from that.
  always_comb begin
    w_wb = '0;
    w_wb[CB_PC_LOAD]  = 1'b1;
    w_wb[CB_PC_SEL_1] = 1'b1;
    w_wb[CB_PC_SEL_3] = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        if (i_funct == FN_JR) begin
          w_wb[CB_PC_SEL_1] = 1'b0;
        end else if (w_alu != ALU_NONE) begin
          w_wb[CB_REG_W]    = 1'b1;
          w_wb[CB_WA_SEL_3] = 1'b1;
          w_wb[CB_WD_SEL_3] = 1'b1;
        end
      end
      OP_ADDI, OP_SLTI, OP_MULI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        w_wb[CB_REG_W]    = 1'b1;
        w_wb[CB_WA_SEL_1] = 1'b1;
        w_wb[CB_WA_SEL_3] = 1'b1;
        w_wb[CB_WD_SEL_3] = 1'b1;
        w_wb[CB_WD_SEL_2] = (i_opcode == OP_LUI);
        w_wb[CB_WD_SEL_1] = (i_opcode == OP_LW);
      end
      OP_BEQ: w_wb[CB_PC_SEL_2] = i_zero_q;
      OP_BNE: w_wb[CB_PC_SEL_2] = ~i_zero_q;
      OP_JMP: w_wb[CB_PC_SEL_3] = 1'b0;
      OP_JAL: begin
        w_wb[CB_PC_SEL_3] = 1'b0;
        w_wb[CB_REG_W]    = 1'b1;
        w_wb[CB_WA_SEL_2] = 1'b1;
      end
      OP_PUSH: w_wb[CB_SP_LOAD] = 1'b1;
      OP_POP: begin
        w_wb[CB_SP_LOAD]  = 1'b1;
        w_wb[CB_REG_W]    = 1'b1;
        w_wb[CB_WD_SEL_3] = 1'b1;
        w_wb[CB_WD_SEL_1] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl[CB_MEM_R]    = 1'b1;
        o_ctrl[CB_MA_SEL_2] = 1'b1;
      end
      ST_DECODE: begin
        o_ctrl[CB_MEM_R]    = 1'b1;
        o_ctrl[CB_MA_SEL_2] = 1'b1;
        o_ctrl[CB_IR_LOAD]  = 1'b1;
        o_ctrl[CB_REG_R]    = 1'b1;
      end
      ST_EXE: begin
        o_ctrl = w_opnd;
        o_ctrl[CB_REG_R] = 1'b1;
      end
      ST_MEM: begin
        o_ctrl = w_opnd | w_mem;
        o_ctrl[CB_REG_R] = 1'b1;
      end
      ST_WB: begin
        o_ctrl = w_opnd | w_wb;
        o_ctrl[CB_REG_R] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// cs147sec05 control sequencer: five-state FSM plus zero-flag capture driving the
// 32-bit CTRL word. Define CU_ILLEGAL_TRAP_EN to halt on unknown instructions.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  output logic [31:0] CTRL,
  output logic        HALTED
);

  state_t      r_state;
  state_t      w_next;
  logic        r_zero_q;
  logic [31:0] w_ctrl;
  opcode_t     w_opcode;
  logic [5:0]  w_funct;
  logic        w_unused;

  assign w_opcode = INSTRUCTION[31:26];
  assign w_funct  = INSTRUCTION[5:0];
  assign w_unused = ^INSTRUCTION[25:6];

  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXE;
`ifdef CU_ILLEGAL_TRAP_EN
      ST_EXE:    w_next = is_legal(w_opcode, w_funct) ? ST_MEM : ST_HALT;
      ST_HALT:   w_next = ST_HALT;
`else
      ST_EXE:    w_next = ST_MEM;
`endif
      ST_MEM:    w_next = ST_WB;
      default:   w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= ST_FETCH;
      r_zero_q <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_EXE)
        r_zero_q <= ZERO;
    end
  end

  ctrl_decode u_ctrl_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .i_funct  (w_funct),
    .i_zero_q (r_zero_q),
    .o_ctrl   (w_ctrl)
  );

  // Masking with RST keeps every strobe low while reset is held, even mid-instruction.
  assign CTRL = RST ? w_ctrl : '0;

`ifdef CU_ILLEGAL_TRAP_EN
  assign HALTED = (r_state == ST_HALT);
`else
  assign HALTED = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction
// streams compared phase by phase against a behavioural CTRL model.
module tb_control_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INSTRUCTION;
  logic        ZERO;
  logic [31:0] CTRL;
  logic        HALTED;

  int checks = 0;
  int errors = 0;
  logic m_zq = 1'b0;

  localparam logic [31:0] FETCH_WORD = 32'h0800_0020;

  localparam int O2_NONE = 0, O2_R2 = 1, O2_SHAMT = 2, O2_ONE = 3, O2_SEXT = 4;
  localparam int M_NONE = 0, M_LOAD = 1, M_STORE = 2, M_PUSH = 3, M_POP = 4;
  localparam int PC_NEXT = 0, PC_BR = 1, PC_R1 = 2, PC_ADDR = 3;
  localparam int WA_NONE = 0, WA_RD = 1, WA_RT = 2, WA_R31 = 3, WA_R0 = 4;
  localparam int WD_ALU = 0, WD_MEM = 1, WD_LUI = 2, WD_PC1 = 3;

  logic [5:0] ops [15] = '{6'h00, 6'h08, 6'h0a, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h04,
                           6'h05, 6'h23, 6'h2b, 6'h02, 6'h03, 6'h1b, 6'h1c};
  logic [5:0] fns [10] = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a,
                           6'h01, 6'h02, 6'h08};

  control_unit u_dut (
    .CLK         (CLK),
    .RST         (RST),
    .INSTRUCTION (INSTRUCTION),
    .ZERO        (ZERO),
    .CTRL        (CTRL),
    .HALTED      (HALTED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // Describes each instruction by what it does, then turns that into CTRL bits.
  function automatic logic [31:0] model_ctrl(input logic [31:0] ins, input int phase,
                                             input logic zq);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  alu;
    int          op2, mem, pc, wa, wd;
    logic        use_sp, sp_ld;
    logic [31:0] c;
    op = ins[31:26]; fn = ins[5:0];
    alu = 4'd0; op2 = O2_NONE; mem = M_NONE; pc = PC_NEXT; wa = WA_NONE; wd = WD_ALU;
    use_sp = 1'b0; sp_ld = 1'b0; c = 32'h0;
    case (op)
      6'h00: case (fn)
        6'h20: begin alu = 4'd1; op2 = O2_R2; wa = WA_RD; end
        6'h22: begin alu = 4'd2; op2 = O2_R2; wa = WA_RD; end
        6'h2c: begin alu = 4'd3; op2 = O2_R2; wa = WA_RD; end
        6'h24: begin alu = 4'd6; op2 = O2_R2; wa = WA_RD; end
        6'h25: begin alu = 4'd7; op2 = O2_R2; wa = WA_RD; end
        6'h27: begin alu = 4'd8; op2 = O2_R2; wa = WA_RD; end
        6'h2a: begin alu = 4'd9; op2 = O2_R2; wa = WA_RD; end
        6'h01: begin alu = 4'd5; op2 = O2_SHAMT; wa = WA_RD; end
        6'h02: begin alu = 4'd4; op2 = O2_SHAMT; wa = WA_RD; end
        6'h08: pc = PC_R1;
        default: ;
      endcase
      6'h08: begin alu = 4'd1; op2 = O2_SEXT; wa = WA_RT; end
      6'h0a: begin alu = 4'd9; op2 = O2_SEXT; wa = WA_RT; end
      6'h1d: begin alu = 4'd3; op2 = O2_SEXT; wa = WA_RT; end
      6'h0c: begin alu = 4'd6; wa = WA_RT; end
      6'h0d: begin alu = 4'd7; wa = WA_RT; end
      6'h0f: begin wa = WA_RT; wd = WD_LUI; end
      6'h04: begin alu = 4'd2; op2 = O2_R2; pc = zq ? PC_BR : PC_NEXT; end
      6'h05: begin alu = 4'd2; op2 = O2_R2; pc = zq ? PC_NEXT : PC_BR; end
      6'h23: begin alu = 4'd1; op2 = O2_SEXT; mem = M_LOAD; wa = WA_RT; wd = WD_MEM; end
      6'h2b: begin alu = 4'd1; op2 = O2_SEXT; mem = M_STORE; end
      6'h02: pc = PC_ADDR;
      6'h03: begin pc = PC_ADDR; wa = WA_R31; wd = WD_PC1; end
      6'h1b: begin alu = 4'd2; use_sp = 1'b1; op2 = O2_ONE; mem = M_PUSH; sp_ld = 1'b1; end
      6'h1c: begin alu = 4'd1; use_sp = 1'b1; op2 = O2_ONE; mem = M_POP; sp_ld = 1'b1;
                   wa = WA_R0; wd = WD_MEM; end
      default: ;
    endcase
    if (phase <= 1) begin
      c[5] = 1'b1; c[27] = 1'b1;
      if (phase == 1) begin c[4] = 1'b1; c[8] = 1'b1; end
    end else begin
      c[8] = 1'b1;
      c[25:22] = alu;
      c[17] = use_sp;
      case (op2)
        O2_R2:    c[21] = 1'b1;
        O2_SHAMT: begin c[20] = 1'b1; c[18] = 1'b1; end
        O2_ONE:   c[20] = 1'b1;
        O2_SEXT:  c[19] = 1'b1;
        default: ;
      endcase
      if (phase == 3) begin
        case (mem)
          M_LOAD, M_POP: c[5] = 1'b1;
          M_STORE: c[6] = 1'b1;
          M_PUSH: begin c[6] = 1'b1; c[26] = 1'b1; c[28] = 1'b1; c[7] = 1'b1; end
          default: ;
        endcase
      end
      if (phase == 4) begin
        c[0] = 1'b1;
        case (pc)
          PC_NEXT: begin c[1] = 1'b1; c[3] = 1'b1; end
          PC_BR:   begin c[1] = 1'b1; c[2] = 1'b1; c[3] = 1'b1; end
          PC_R1:   c[3] = 1'b1;
          default: c[1] = 1'b1;
        endcase
        c[16] = sp_ld;
        if (wa != WA_NONE) begin
          c[9] = 1'b1;
          case (wa)
            WA_RD:  c[12] = 1'b1;
            WA_RT:  begin c[10] = 1'b1; c[12] = 1'b1; end
            WA_R31: c[11] = 1'b1;
            default: ;
          endcase
          case (wd)
            WD_ALU: c[15] = 1'b1;
            WD_MEM: begin c[15] = 1'b1; c[13] = 1'b1; end
            WD_LUI: begin c[15] = 1'b1; c[14] = 1'b1; end
            default: ;
          endcase
        end
      end
    end
    return c;
  endfunction

  task automatic test_reset();
    RST = 1'b0; INSTRUCTION = '0; ZERO = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK); #1;
      checks++;
      if (CTRL !== 32'h0 || HALTED !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: CTRL=%h HALTED=%b, required CTRL=00000000 HALTED=0", CTRL, HALTED);
      end
    end
    RST = 1'b1; m_zq = 1'b0; #1;
    checks++;
    if (CTRL !== FETCH_WORD || HALTED !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_fetch: CTRL=%h HALTED=%b, required CTRL=%h HALTED=0", CTRL, HALTED, FETCH_WORD);
    end
  endtask

  task automatic test_addi();
    logic [31:0] ins, exp_c;
    ins = {6'h08, 5'd1, 5'd2, 16'hFFFF};
    INSTRUCTION = ins;
    for (int p = 0; p < 5; p++) begin
      ZERO = (p == 2) ? 1'b0 : 1'($urandom_range(0, 1)); #1;
      exp_c = model_ctrl(ins, p, m_zq);
      checks++;
      if (CTRL !== exp_c || HALTED !== 1'b0) begin
        errors++;
        $display("FAIL addi phase %0d: CTRL=%h HALTED=%b, required CTRL=%h HALTED=0", p, CTRL, HALTED, exp_c);
      end
      if (p == 2) m_zq = ZERO;
      @(negedge CLK);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins, exp_c;
    for (int k = 0; k < 4; k++) begin
      ins = {(k < 2) ? 6'h04 : 6'h05, 5'd1, 5'd2, 16'h0004};
      INSTRUCTION = ins;
      for (int p = 0; p < 5; p++) begin
        ZERO = (p == 2) ? ((k % 2) == 0) : 1'($urandom_range(0, 1)); #1;
        exp_c = model_ctrl(ins, p, m_zq);
        checks++;
        if (CTRL !== exp_c || HALTED !== 1'b0) begin
          errors++;
          $display("FAIL branch op=%h zero_exe=%0d phase %0d: CTRL=%h, required %h", ins[31:26], (k % 2) == 0, p, CTRL, exp_c);
        end
        if (p == 2) m_zq = ZERO;
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] ins, exp_c;
    for (int k = 0; k < 2; k++) begin
      ins = {(k == 0) ? 6'h1b : 6'h1c, 26'h0};
      INSTRUCTION = ins;
      for (int p = 0; p < 5; p++) begin
        ZERO = 1'($urandom_range(0, 1)); #1;
        exp_c = model_ctrl(ins, p, m_zq);
        checks++;
        if (CTRL !== exp_c || HALTED !== 1'b0) begin
          errors++;
          $display("FAIL %s phase %0d: CTRL=%h, required %h", (k == 0) ? "push" : "pop", p, CTRL, exp_c);
        end
        if (p == 2) m_zq = ZERO;
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_jal();
    logic [31:0] ins, exp_c;
    ins = {6'h03, 26'h0000100};
    INSTRUCTION = ins;
    for (int p = 0; p < 5; p++) begin
      ZERO = 1'($urandom_range(0, 1)); #1;
      exp_c = model_ctrl(ins, p, m_zq);
      checks++;
      if (CTRL !== exp_c || HALTED !== 1'b0) begin
        errors++;
        $display("FAIL jal phase %0d: CTRL=%h, required %h", p, CTRL, exp_c);
      end
      if (p == 2) m_zq = ZERO;
      @(negedge CLK);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins, exp_c;
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 14)];
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 9)];
`ifndef CU_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) ins[31:26] = 6'h3e;
`endif
      INSTRUCTION = ins;
      for (int p = 0; p < 5; p++) begin
        ZERO = 1'($urandom_range(0, 1)); #1;
        exp_c = model_ctrl(ins, p, m_zq);
        checks++;
        if (CTRL !== exp_c || HALTED !== 1'b0) begin
          errors++;
          $display("FAIL random ins=%h phase %0d: CTRL=%h HALTED=%b, required CTRL=%h HALTED=0", ins, p, CTRL, HALTED, exp_c);
        end
        if (p == 2) m_zq = ZERO;
        @(negedge CLK);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins, exp_c;
    for (int k = 0; k < 2; k++) begin
      ins = (k == 0) ? {6'h3f, 26'h0} : {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h3f};
      INSTRUCTION = ins;
`ifdef CU_ILLEGAL_TRAP_EN
      for (int p = 0; p < 3; p++) begin
        ZERO = 1'($urandom_range(0, 1)); #1;
        exp_c = model_ctrl(ins, p, m_zq);
        checks++;
        if (CTRL !== exp_c || HALTED !== 1'b0) begin
          errors++;
          $display("FAIL illegal_pre_halt ins=%h phase %0d: CTRL=%h, required %h", ins, p, CTRL, exp_c);
        end
        @(negedge CLK);
      end
      for (int h = 0; h < 3; h++) begin
        #1;
        checks++;
        if (CTRL !== 32'h0 || HALTED !== 1'b1) begin
          errors++;
          $display("FAIL illegal_halt ins=%h cycle %0d: CTRL=%h HALTED=%b, required CTRL=00000000 HALTED=1", ins, h, CTRL, HALTED);
        end
        @(negedge CLK);
      end
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1; m_zq = 1'b0; #1;
      checks++;
      if (CTRL !== FETCH_WORD || HALTED !== 1'b0) begin
        errors++;
        $display("FAIL halt_reset_exit: CTRL=%h HALTED=%b, required CTRL=%h HALTED=0", CTRL, HALTED, FETCH_WORD);
      end
`else
      for (int p = 0; p < 5; p++) begin
        ZERO = 1'($urandom_range(0, 1)); #1;
        exp_c = model_ctrl(ins, p, m_zq);
        checks++;
        if (CTRL !== exp_c || HALTED !== 1'b0) begin
          errors++;
          $display("FAIL illegal_nop ins=%h phase %0d: CTRL=%h HALTED=%b, required CTRL=%h HALTED=0", ins, p, CTRL, HALTED, exp_c);
        end
        if (p == 2) m_zq = ZERO;
        @(negedge CLK);
      end
`endif
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] ins, exp_c;
    ins = {6'h2b, 5'd1, 5'd2, 16'h0010};
    INSTRUCTION = ins;
    for (int p = 0; p < 3; p++) begin
      ZERO = 1'($urandom_range(0, 1)); #1;
      exp_c = model_ctrl(ins, p, m_zq);
      checks++;
      if (CTRL !== exp_c) begin
        errors++;
        $display("FAIL abort_pre phase %0d: CTRL=%h, required %h", p, CTRL, exp_c);
      end
      @(negedge CLK);
    end
    RST = 1'b0; #1;
    checks++;
    if (CTRL !== 32'h0) begin
      errors++;
      $display("FAIL abort_mem_forced_zero: CTRL=%h, required 00000000", CTRL);
    end
    @(negedge CLK); #1;
    checks++;
    if (CTRL !== 32'h0) begin
      errors++;
      $display("FAIL abort_hold: CTRL=%h, required 00000000", CTRL);
    end
    RST = 1'b1; m_zq = 1'b0; #1;
    ins = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    INSTRUCTION = ins;
    for (int p = 0; p < 5; p++) begin
      ZERO = 1'($urandom_range(0, 1)); #1;
      exp_c = model_ctrl(ins, p, m_zq);
      checks++;
      if (CTRL !== exp_c || HALTED !== 1'b0) begin
        errors++;
        $display("FAIL abort_resume phase %0d: CTRL=%h, required %h", p, CTRL, exp_c);
      end
      if (p == 2) m_zq = ZERO;
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_push_pop();
    test_jal();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
